// File: rtl/rgmii_pkg.sv
// rgmii_pkg: speed encodings, clock divider defaults and TXC pattern helper for the RGMII TX encoder.
package rgmii_pkg;
  typedef enum logic [1:0] {
    SPEED_10M  = 2'b00,
    SPEED_100M = 2'b01,
    SPEED_1G   = 2'b10
  } speed_e;
  localparam int TXC100_HI_HALF = 5;
  localparam int TXC100_LO_HALF = 5;
  localparam int DIV_100M_DEF   = (TXC100_HI_HALF + TXC100_LO_HALF) / 2;
  localparam int DIV_10M_DEF    = 50;
  function automatic speed_e speed_norm(input logic [1:0] s);
    return s[1] ? SPEED_1G : speed_e'(s);
  endfunction
  // d1 is half-cycle 2*cnt, d2 is 2*cnt+1; the first div half-cycles of the period are high
  function automatic logic [1:0] txc_pat(input int div, input int cnt);
    return {2 * cnt < div, 2 * cnt + 1 < div};
  endfunction
endpackage

// File: rtl/rgmii_tx_clk_gen.sv
// rgmii_tx_clk_gen: active speed, period counter, MAC strobe and forwarded-clock pattern.
// Speed is only re-sampled on period boundaries so TXC never glitches.
module rgmii_tx_clk_gen
  import rgmii_pkg::*;
#(
  parameter int DIV_100M = DIV_100M_DEF,
  parameter int DIV_10M  = DIV_10M_DEF,
  parameter int CNT_W    = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_speed,
  output speed_e     o_spd_q,
  output logic       o_strobe,
  output logic       o_txc_d1,
  output logic       o_txc_d2
);
  speed_e           r_spd;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_txc;
  speed_e           w_spd_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [1:0]       w_txc;
  logic             w_bnd;
  function automatic int div_of(input speed_e s);
    return s == SPEED_10M ? DIV_10M : DIV_100M;
  endfunction
  assign w_bnd     = r_spd == SPEED_1G || r_cnt == CNT_W'(div_of(r_spd) - 1);
  assign w_spd_nxt = w_bnd ? speed_norm(i_speed) : r_spd;
  assign w_cnt_nxt = w_bnd ? '0 : r_cnt + 1'b1;
  // TXC is registered alongside the data, so the pattern follows the upcoming count
  assign w_txc     = w_spd_nxt == SPEED_1G ? 2'b10 : txc_pat(div_of(w_spd_nxt), int'(w_cnt_nxt));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_spd <= SPEED_1G;
      r_cnt <= '0;
      r_txc <= '0;
    end else begin
      r_spd <= w_spd_nxt;
      r_cnt <= w_cnt_nxt;
      r_txc <= w_txc;
    end
  assign o_spd_q              = r_spd;
  assign o_strobe             = w_bnd;
  assign {o_txc_d1, o_txc_d2} = r_txc;
endmodule

// File: rtl/rgmii_tx_ddr_encoder.sv
// rgmii_tx_ddr_encoder: GMII-to-RGMII TX DDR feeder for 1G/100M/10M.
// Optional saturating TX error counter enabled by RGMII_TX_ERR_CNT_EN.
module rgmii_tx_ddr_encoder
  import rgmii_pkg::*;
#(
  parameter int DIV_100M = DIV_100M_DEF,
  parameter int DIV_10M  = DIV_10M_DEF,
  parameter int CNT_W    = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  speed,
  input  logic [7:0]  mac_txd,
  input  logic        mac_tx_en,
  input  logic        mac_tx_er,
  output logic        mac_tx_clk_en,
  output logic [3:0]  txd_d1,
  output logic [3:0]  txd_d2,
  output logic        tx_ctl_d1,
  output logic        tx_ctl_d2,
  output logic        txc_d1,
  output logic        txc_d2
`ifdef RGMII_TX_ERR_CNT_EN
  ,
  output logic [15:0] tx_err_cnt
`endif
);
  speed_e     w_spd_q;
  logic       w_stb;
  logic [9:0] r_out;
  rgmii_tx_clk_gen #(
    .DIV_100M(DIV_100M),
    .DIV_10M (DIV_10M),
    .CNT_W   (CNT_W)
  ) u_clk_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_speed (speed),
    .o_spd_q (w_spd_q),
    .o_strobe(w_stb),
    .o_txc_d1(txc_d1),
    .o_txc_d2(txc_d2)
  );
  // at 10/100 the nibble is driven on both edges and held for the whole TXC period
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_out <= '0;
    else if (w_stb)
      r_out <= {mac_txd[3:0], (w_spd_q == SPEED_1G ? mac_txd[7:4] : mac_txd[3:0]),
                mac_tx_en, mac_tx_en ^ mac_tx_er};
  assign {txd_d1, txd_d2, tx_ctl_d1, tx_ctl_d2} = r_out;
  assign mac_tx_clk_en = w_stb;
`ifdef RGMII_TX_ERR_CNT_EN
  logic [15:0] r_err_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_err_cnt <= '0;
    else if (w_stb && mac_tx_en && mac_tx_er && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 1'b1;
  assign tx_err_cnt = r_err_cnt;
`endif
endmodule

// File: tb/tb_rgmii_tx_ddr_encoder.sv
// tb_rgmii_tx_ddr_encoder: directed self-checking bench for rgmii_tx_ddr_encoder.
// Define RGMII_TX_ERR_CNT_EN to also exercise the error counter.
`timescale 1ns/1ps
module tb_rgmii_tx_ddr_encoder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  speed = 2'b10;
  logic [7:0]  mac_txd = 8'h00;
  logic        mac_tx_en = 1'b0;
  logic        mac_tx_er = 1'b0;
  logic        mac_tx_clk_en;
  logic [3:0]  txd_d1, txd_d2;
  logic        tx_ctl_d1, tx_ctl_d2, txc_d1, txc_d2;
  logic [9:0]  w_dat;
  logic [1:0]  w_txc;
  int          n_chk = 0;
  int          n_fail = 0;
`ifdef RGMII_TX_ERR_CNT_EN
  logic [15:0] tx_err_cnt;
`endif

  rgmii_tx_ddr_encoder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .speed        (speed),
    .mac_txd      (mac_txd),
    .mac_tx_en    (mac_tx_en),
    .mac_tx_er    (mac_tx_er),
    .mac_tx_clk_en(mac_tx_clk_en),
    .txd_d1       (txd_d1),
    .txd_d2       (txd_d2),
    .tx_ctl_d1    (tx_ctl_d1),
    .tx_ctl_d2    (tx_ctl_d2),
    .txc_d1       (txc_d1),
    .txc_d2       (txc_d2)
`ifdef RGMII_TX_ERR_CNT_EN
    ,
    .tx_err_cnt   (tx_err_cnt)
`endif
  );

  always #4 clk = ~clk;
  assign w_dat = {txd_d1, txd_d2, tx_ctl_d1, tx_ctl_d2};
  assign w_txc = {txc_d1, txc_d2};

  task automatic drive_junk();
    mac_txd   = 8'($urandom);
    mac_tx_en = 1'($urandom);
    mac_tx_er = 1'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    speed = 2'($urandom);
    drive_junk();
    repeat (3) @(negedge clk);
    n_chk++;
    if ({w_dat, w_txc} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want %h", {w_dat, w_txc}, 12'h000);
    end
    speed = 2'b10;
    mac_txd = 8'h00;
    mac_tx_en = 1'b0;
    mac_tx_er = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_chk++;
      if ({w_dat, w_txc, mac_tx_clk_en} !== 13'h0005) begin
        n_fail++;
        $display("FAIL reset_release_1g cyc %0d: got %h want %h", i, {w_dat, w_txc, mac_tx_clk_en}, 13'h0005);
      end
    end
  endtask

  task automatic test_1g();
    mac_txd = 8'hA5; mac_tx_en = 1'b1; mac_tx_er = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({w_dat, w_txc} !== {4'h5, 4'hA, 2'b11, 2'b10}) begin
      n_fail++;
      $display("FAIL 1g_a5: got %h want %h", {w_dat, w_txc}, {4'h5, 4'hA, 2'b11, 2'b10});
    end
    mac_tx_er = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({w_dat, w_txc} !== {4'h5, 4'hA, 2'b10, 2'b10}) begin
      n_fail++;
      $display("FAIL 1g_err: got %h want %h", {w_dat, w_txc}, {4'h5, 4'hA, 2'b10, 2'b10});
    end
    speed = 2'b11; mac_txd = 8'h3C; mac_tx_er = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({w_dat, w_txc, mac_tx_clk_en} !== {4'hC, 4'h3, 2'b11, 2'b10, 1'b1}) begin
      n_fail++;
      $display("FAIL 1g_code11: got %h want %h", {w_dat, w_txc, mac_tx_clk_en}, {4'hC, 4'h3, 2'b11, 2'b10, 1'b1});
    end
    mac_txd = 8'h00; mac_tx_en = 1'b0; mac_tx_er = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({w_dat, w_txc} !== {4'h0, 4'h0, 2'b01, 2'b10}) begin
      n_fail++;
      $display("FAIL 1g_er_only: got %h want %h", {w_dat, w_txc}, {4'h0, 4'h0, 2'b01, 2'b10});
    end
  endtask

  // 1G -> 100M switch, then three 100M periods with the 1G word held through the first
  task automatic test_100m();
    logic [1:0] tbl [5] = '{2'b11, 2'b11, 2'b10, 2'b00, 2'b00};
    logic [9:0] exp_dat = {4'h3, 4'hF, 2'b11};
    speed = 2'b01; mac_txd = 8'hF3; mac_tx_en = 1'b1; mac_tx_er = 1'b0;
    for (int p = 0; p < 3; p++)
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        n_chk++;
        if (mac_tx_clk_en !== (c == 4)) begin
          n_fail++;
          $display("FAIL 100m_strobe p%0d c%0d: got %b want %b", p, c, mac_tx_clk_en, c == 4);
        end
        n_chk++;
        if (w_txc !== tbl[c]) begin
          n_fail++;
          $display("FAIL 100m_txc p%0d c%0d: got %b want %b", p, c, w_txc, tbl[c]);
        end
        n_chk++;
        if (w_dat !== exp_dat) begin
          n_fail++;
          $display("FAIL 100m_data p%0d c%0d: got %h want %h", p, c, w_dat, exp_dat);
        end
        drive_junk();
        if (c == 4 && p == 0) begin
          mac_txd = 8'hA3; mac_tx_en = 1'b1; mac_tx_er = 1'b0; exp_dat = {4'h3, 4'h3, 2'b11};
        end else if (c == 4 && p == 1) begin
          mac_txd = 8'h5C; mac_tx_en = 1'b1; mac_tx_er = 1'b1; exp_dat = {4'hC, 4'hC, 2'b10};
        end else if (c == 4) begin
          mac_txd = 8'h66; mac_tx_en = 1'b0; mac_tx_er = 1'b0; exp_dat = {4'h6, 4'h6, 2'b00};
        end
      end
  endtask

  // request 10M at cnt 2: the running 100M period must complete unchanged
  task automatic test_speed_change();
    logic [1:0] tbl [5] = '{2'b11, 2'b11, 2'b10, 2'b00, 2'b00};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_chk++;
      if ({mac_tx_clk_en, w_txc} !== {c == 4, tbl[c]}) begin
        n_fail++;
        $display("FAIL chg_tail c%0d: got %b want %b", c, {mac_tx_clk_en, w_txc}, {c == 4, tbl[c]});
      end
      n_chk++;
      if (w_dat !== {4'h6, 4'h6, 2'b00}) begin
        n_fail++;
        $display("FAIL chg_data c%0d: got %h want %h", c, w_dat, {4'h6, 4'h6, 2'b00});
      end
      drive_junk();
      if (c == 2) speed = 2'b00;
      if (c == 4) begin
        mac_txd = 8'h07; mac_tx_en = 1'b1; mac_tx_er = 1'b0;
      end
    end
  endtask

  // one full 10M period; 100M is requested mid-period for the next test
  task automatic test_10m();
    int hi = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      hi += int'(txc_d1);
      n_chk++;
      if ({mac_tx_clk_en, w_txc} !== {c == 49, (c < 25) ? 2'b11 : 2'b00}) begin
        n_fail++;
        $display("FAIL 10m_txc c%0d: got %b want %b", c, {mac_tx_clk_en, w_txc}, {c == 49, (c < 25) ? 2'b11 : 2'b00});
      end
      n_chk++;
      if (w_dat !== {4'h7, 4'h7, 2'b11}) begin
        n_fail++;
        $display("FAIL 10m_data c%0d: got %h want %h", c, w_dat, {4'h7, 4'h7, 2'b11});
      end
      drive_junk();
      if (c == 10) speed = 2'b01;
      if (c == 49) begin
        mac_txd = 8'hE9; mac_tx_en = 1'b1; mac_tx_er = 1'b1;
      end
    end
    n_chk++;
    if (hi != 25) begin
      n_fail++;
      $display("FAIL 10m_high_count: got %0d want %0d", hi, 25);
    end
  endtask

  // back at 100M, assert reset asynchronously at cnt 3
  task automatic test_async_reset();
    logic [1:0] tbl [4] = '{2'b11, 2'b11, 2'b10, 2'b00};
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_chk++;
      if ({mac_tx_clk_en, w_txc, w_dat} !== {1'b0, tbl[c], 4'h9, 4'h9, 2'b10}) begin
        n_fail++;
        $display("FAIL rst_pre c%0d: got %h want %h", c, {mac_tx_clk_en, w_txc, w_dat}, {1'b0, tbl[c], 4'h9, 4'h9, 2'b10});
      end
      drive_junk();
    end
    #1 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({w_dat, w_txc, mac_tx_clk_en} !== 13'h0001) begin
      n_fail++;
      $display("FAIL rst_async: got %h want %h", {w_dat, w_txc, mac_tx_clk_en}, 13'h0001);
    end
    @(negedge clk);
    n_chk++;
    if ({w_dat, w_txc} !== 12'h000) begin
      n_fail++;
      $display("FAIL rst_held: got %h want %h", {w_dat, w_txc}, 12'h000);
    end
    speed = 2'b10; mac_txd = 8'h00; mac_tx_en = 1'b0; mac_tx_er = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({w_dat, w_txc, mac_tx_clk_en} !== 13'h0005) begin
      n_fail++;
      $display("FAIL rst_release: got %h want %h", {w_dat, w_txc, mac_tx_clk_en}, 13'h0005);
    end
  endtask

`ifdef RGMII_TX_ERR_CNT_EN
  task automatic test_err_cnt();
    n_chk++;
    if (tx_err_cnt !== 16'h0000) begin
      n_fail++;
      $display("FAIL err_cnt_reset: got %h want %h", tx_err_cnt, 16'h0000);
    end
    mac_tx_en = 1'b1; mac_tx_er = 1'b1;
    repeat (3) @(negedge clk);
    mac_tx_en = 1'b0;
    @(negedge clk);
    n_chk++;
    if (tx_err_cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL err_cnt_three: got %h want %h", tx_err_cnt, 16'd3);
    end
    mac_tx_en = 1'b1;
    repeat (65531) @(negedge clk);
    mac_tx_en = 1'b0;
    @(negedge clk);
    n_chk++;
    if (tx_err_cnt !== 16'hFFFE) begin
      n_fail++;
      $display("FAIL err_cnt_near_sat: got %h want %h", tx_err_cnt, 16'hFFFE);
    end
    mac_tx_en = 1'b1;
    repeat (5) @(negedge clk);
    mac_tx_en = 1'b0;
    @(negedge clk);
    n_chk++;
    if (tx_err_cnt !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL err_cnt_sat: got %h want %h", tx_err_cnt, 16'hFFFF);
    end
  endtask
`else
  task automatic test_err_cnt();
    $display("error counter not built; skipping");
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_1g();
    test_100m();
    test_speed_change();
    test_10m();
    test_async_reset();
    test_err_cnt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
